// File: rtl/regbank_s8_arbiter.sv
// Two-client round-robin arbiter and sequencer in front of the 8x8 register bank.
// Supports client bus locking with an idle timeout, and drops illegal opcodes before they reach the bank.
module regbank_s8_arbiter #(
    parameter int unsigned LOCK_TIMEOUT = 16,
    parameter int unsigned LOCK_CNT_W   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [11:0] req0_inst,
    input  logic        req0_lock,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [11:0] req1_inst,
    input  logic        req1_lock,
    output logic        req1_ready,
    output logic [11:0] inst,
    output logic        inst_en,
    output logic        grant_id,
    output logic [1:0]  lock_owner,
    output logic        err_illegal,
    output logic        lock_timeout
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_READY = 2'd1,
        ST_LOCK0 = 2'd2,
        ST_LOCK1 = 2'd3
    } state_t;

    localparam logic [LOCK_CNT_W-1:0] IDLE_LAST = LOCK_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]            OP_MAX    = 4'h9;

    state_t                  state_q, state_d;
    logic                    ptr_q, ptr_d;
    logic [LOCK_CNT_W-1:0]   cnt_q, cnt_d;
    logic [11:0]             inst_q, inst_d;
    logic                    inst_en_q, inst_en_d;
    logic                    grant_q, grant_d;
    logic                    err_q, err_d;

    logic                    rdy0, rdy1;
    logic                    timeout;
    logic                    xfer;
    logic                    xid;
    logic [11:0]             x_inst;
    logic                    x_lock;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RESET;
            ptr_q     <= 1'b0;
            cnt_q     <= '0;
            inst_q    <= '0;
            inst_en_q <= 1'b0;
            grant_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            inst_q    <= inst_d;
            inst_en_q <= inst_en_d;
            grant_q   <= grant_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        inst_d    = inst_q;
        inst_en_d = 1'b0;
        grant_d   = grant_q;
        err_d     = err_q;
        rdy0      = 1'b0;
        rdy1      = 1'b0;
        timeout   = 1'b0;

        case (state_q)
            ST_RESET: state_d = ST_READY;
            ST_READY: begin
                if (req0_valid && (!req1_valid || !ptr_q)) begin
                    rdy0 = 1'b1;
                end else if (req1_valid) begin
                    rdy1 = 1'b1;
                end
            end
            ST_LOCK0: begin
                rdy0 = req0_valid;
                if (!req0_valid) begin
                    if (cnt_q == IDLE_LAST) timeout = 1'b1;
                    else                    cnt_d   = cnt_q + LOCK_CNT_W'(1);
                end
            end
            ST_LOCK1: begin
                rdy1 = req1_valid;
                if (!req1_valid) begin
                    if (cnt_q == IDLE_LAST) timeout = 1'b1;
                    else                    cnt_d   = cnt_q + LOCK_CNT_W'(1);
                end
            end
            default: state_d = ST_RESET;
        endcase

        xfer   = rdy0 | rdy1;
        xid    = rdy1;
        x_inst = rdy1 ? req1_inst : req0_inst;
        x_lock = rdy1 ? req1_lock : req0_lock;

        // Timeout and transfer are mutually exclusive: timeout needs the holder idle.
        if (timeout) begin
            state_d = ST_READY;
            cnt_d   = '0;
            ptr_d   = (state_q == ST_LOCK0);
        end

        if (xfer) begin
            ptr_d   = ~xid;
            cnt_d   = '0;
            state_d = x_lock ? (xid ? ST_LOCK1 : ST_LOCK0) : ST_READY;
            if (x_inst[11:8] <= OP_MAX) begin
                inst_d    = x_inst;
                inst_en_d = 1'b1;
                grant_d   = xid;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    assign req0_ready   = rdy0;
    assign req1_ready   = rdy1;
    assign inst         = inst_q;
    assign inst_en      = inst_en_q;
    assign grant_id     = grant_q;
    assign lock_owner   = {state_q == ST_LOCK1, state_q == ST_LOCK0};
    assign err_illegal  = err_q;
    assign lock_timeout = timeout;

endmodule
